mem_sweep_ctrl: RTL and testbench

- Sequencer that owns both ports of one simple dual-port block RAM instance and runs whole-range or sub-range sweeps: FILL writes a generated pattern; VERIFY reads back, compares against the same pattern, and reports a mismatch count and the first failing address.
- Sits between the top-level test harness and the memory instance.
- Used to re-establish and check known memory contents after bitstream-level memory reinitialisation.

---
 rtl/mem_sweep_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mem_sweep_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sweep_ctrl.sv
// mem_sweep_ctrl: drives both ports of a simple dual-port RAM to FILL a pattern or VERIFY it.
// Build option MEM_SWEEP_STOP_ON_FAIL_EN: VERIFY ends at the first mismatch. Revision 1.0.
`default_nettype none

module mem_sweep_ctrl #(
    parameter int WID_MEM   = 1,
    parameter int DEPTH_MEM = 32768,
    parameter int ERR_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic               pat_sel,
    input  logic [WID_MEM-1:0] seed,
    input  logic [31:0]        base_addr,
    input  logic [31:0]        length,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [31:0]        fail_addr,
    output logic [31:0]        mem_raddr,
    output logic [31:0]        mem_waddr,
    output logic [WID_MEM-1:0] mem_din,
    output logic               mem_we,
    input  logic [WID_MEM-1:0] mem_dout
);

    localparam int AW = (DEPTH_MEM > 1) ? $clog2(DEPTH_MEM) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_VERIFY = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        k_q, k_d;
    logic [31:0]        len_q, len_d;
    logic [AW-1:0]      base_q, base_d;
    logic               pat_q, pat_d;
    logic [WID_MEM-1:0] seed_q, seed_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [31:0]        fail_q, fail_d;
    logic               pass_q, pass_d;
    logic [AW-1:0]      raddr_q, raddr_d;
    logic [AW-1:0]      waddr_q, waddr_d;
    logic [WID_MEM-1:0] din_q, din_d;
    logic               vld_q, vld_d;
    logic [AW-1:0]      paddr_q, paddr_d;

    logic [AW-1:0]      w_addr;
    logic [WID_MEM-1:0] w_pat;
    logic               w_last;
    logic               w_mis;

    function automatic logic [WID_MEM-1:0] pattern(input logic sel, input logic [WID_MEM-1:0] sd,
                                                   input logic [AW-1:0] a);
        return sel ? (WID_MEM'(32'(a)) ^ sd) : sd;
    endfunction

    // Address arithmetic is done in AW bits so the sweep wraps at the top of the RAM.
    assign w_addr = base_q + k_q[AW-1:0];
    assign w_pat  = pattern(pat_q, seed_q, w_addr);
    assign w_last = (k_q == len_q - 32'd1);
    assign w_mis  = vld_q && (mem_dout != pattern(pat_q, seed_q, paddr_q));

    generate
        if (AW < 32) begin : g_unused_base
            logic unused_base_hi;
            assign unused_base_hi = ^base_addr[31:AW];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        len_d   = len_q;
        base_d  = base_q;
        pat_d   = pat_q;
        seed_d  = seed_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        din_d   = din_q;
        vld_d   = 1'b0;
        paddr_d = paddr_q;

        // Score the read issued last cycle; err_q==0 marks the first mismatch of this VERIFY.
        if ((state_q == S_VERIFY || state_q == S_DRAIN) && w_mis) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (err_q == '0) fail_d = 32'(paddr_q);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d  = length;
                    base_d = base_addr[AW-1:0];
                    pat_d  = pat_sel;
                    seed_d = seed;
                    k_d    = '0;
                    if (mode) begin
                        err_d  = '0;
                        fail_d = '0;
                    end else begin
                        pass_d = 1'b1;
                    end
                    if (length == 32'd0) begin
                        state_d = S_DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = mode ? S_VERIFY : S_FILL;
                    end
                end
            end
            S_FILL: begin
                waddr_d = w_addr;
                din_d   = w_pat;
                k_d     = k_q + 32'd1;
                if (w_last) state_d = S_DONE;
            end
            S_VERIFY: begin
                raddr_d = w_addr;
                paddr_d = w_addr;
                vld_d   = 1'b1;
                k_d     = k_q + 32'd1;
                if (w_last) state_d = S_DRAIN;
`ifdef MEM_SWEEP_STOP_ON_FAIL_EN
                if (w_mis) begin
                    state_d = S_DONE;
                    vld_d   = 1'b0;
                    pass_d  = 1'b0;
                end
`endif
            end
            S_DRAIN: begin
                state_d = S_DONE;
                pass_d  = (err_d == '0);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            len_q   <= '0;
            base_q  <= '0;
            pat_q   <= 1'b0;
            seed_q  <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
            raddr_q <= '0;
            waddr_q <= '0;
            din_q   <= '0;
            vld_q   <= 1'b0;
            paddr_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            len_q   <= len_d;
            base_q  <= base_d;
            pat_q   <= pat_d;
            seed_q  <= seed_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
            vld_q   <= vld_d;
            paddr_q <= paddr_d;
        end
    end

    // Buses show the live sweep address and otherwise hold the last value driven.
    assign mem_we    = (state_q == S_FILL);
    assign mem_waddr = 32'(mem_we ? w_addr : waddr_q);
    assign mem_din   = mem_we ? w_pat : din_q;
    assign mem_raddr = 32'((state_q == S_VERIFY) ? w_addr : raddr_q);
    assign busy      = (state_q == S_FILL) || (state_q == S_VERIFY) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign fail_addr = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_sweep_ctrl.sv
// tb_mem_sweep_ctrl: randomized FILL/VERIFY sweeps against a shadow-memory reference model.
`default_nettype none

module tb_mem_sweep_ctrl;

    localparam int          W  = 1;
    localparam int unsigned D  = 32768;
    localparam int          AW = 15;

    logic         clk = 1'b0;
    logic         reset, start, mode, pat_sel;
    logic [W-1:0] seed;
    logic [31:0]  base_addr, length;
    logic         busy, done, pass, mem_we;
    logic [31:0]  err_cnt, fail_addr, mem_raddr, mem_waddr;
    logic [W-1:0] mem_din, mem_dout;

    always #5 clk = ~clk;

    mem_sweep_ctrl #(.WID_MEM(W), .DEPTH_MEM(D), .ERR_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .pat_sel(pat_sel),
        .seed(seed), .base_addr(base_addr), .length(length), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .fail_addr(fail_addr), .mem_raddr(mem_raddr),
        .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
    );

    // Bench-owned RAM with an extra write port used to plant corrupted words.
    logic [W-1:0]  ram [D];
    logic          tb_we;
    logic [AW-1:0] tb_wa;
    logic [W-1:0]  tb_wd;

    always @(posedge clk) begin
        if (tb_we) ram[tb_wa] <= tb_wd;
        else if (mem_we) ram[mem_waddr[AW-1:0]] <= mem_din;
        mem_dout <= ram[mem_raddr[AW-1:0]];
    end

    // Reference model: expected memory contents plus expected held bus/status values.
    logic [W-1:0] model_mem [D];
    int unsigned  h_w, h_r;
    logic [W-1:0] h_d;
    bit           m_pass;
    int unsigned  m_err, m_fail;
    int           n_cmp = 0;
    int           n_mis = 0;

    function automatic logic [W-1:0] pat(input bit ps, input logic [W-1:0] sd, input int unsigned a);
        return ps ? (W'(a) ^ sd) : sd;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string nm, input bit e_busy, input bit e_done,
                                 input bit e_we, input bit chk_stat);
        chk({nm, ".busy_done_we_pass"}, {60'd0, busy, done, mem_we, pass},
            {60'd0, e_busy, e_done, e_we, m_pass});
        chk({nm, ".waddr"}, 64'(mem_waddr), 64'(h_w));
        chk({nm, ".din"}, 64'(mem_din), 64'(h_d));
        chk({nm, ".raddr"}, 64'(mem_raddr), 64'(h_r));
        if (chk_stat) begin
            chk({nm, ".err_cnt"}, 64'(err_cnt), 64'(m_err));
            chk({nm, ".fail_addr"}, 64'(fail_addr), 64'(m_fail));
        end
    endtask

    task automatic model_reset();
        h_w = 0; h_r = 0; h_d = '0; m_pass = 1'b0; m_err = 0; m_fail = 0;
    endtask

    task automatic corrupt(input int unsigned a);
        logic [W-1:0] v;
        v = ~model_mem[a % D];
        model_mem[a % D] = v;
        @(negedge clk);
        tb_we = 1'b1; tb_wa = AW'(a % D); tb_wd = v;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // One sweep: start in cycle 0, then check every cycle up to the idle cycle after done.
    task automatic do_op(input bit m, input bit ps, input logic [W-1:0] sd, input int unsigned b,
                         input int unsigned L, input int abort_at,
                         output int seen_done, output int we_cnt);
        int unsigned e_err, e_fail, first_j;
        bit          found, stop;
        int          done_c;
        e_err = 0; e_fail = 0; first_j = 0; found = 1'b0;
        if (m) begin
            for (int unsigned j = 0; j < L; j++) begin
                int unsigned a;
                a = (b + j) % D;
                if (model_mem[a] != pat(ps, sd, a)) begin
                    if (!found) begin found = 1'b1; e_fail = a; first_j = j; end
                    e_err++;
                end
            end
        end
`ifdef MEM_SWEEP_STOP_ON_FAIL_EN
        stop = found;
        if (found) e_err = 1;
`else
        stop = 1'b0;
`endif
        if (L == 0)      done_c = 1;
        else if (!m)     done_c = int'(L) + 1;
        else if (stop)   done_c = int'(first_j) + 3;
        else             done_c = int'(L) + 2;
        seen_done = -1;
        we_cnt    = 0;

        @(negedge clk);
        check_outputs("idle", 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b1; mode = m; pat_sel = ps; seed = sd; base_addr = b; length = L;

        for (int c = 1; c <= done_c + 1; c++) begin
            bit e_we;
            @(negedge clk);
            if (c == abort_at) begin
                reset = 1'b1;
                start = 1'b0;
                #1;
                model_reset();
                check_outputs("abort", 1'b0, 1'b0, 1'b0, 1'b1);
                @(posedge clk);
                #1;
                chk("abort_no_done", 64'(done), 64'd0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            e_we = 1'b0;
            if (!m && c <= int'(L) && c < done_c) begin
                h_w = (b + c - 1) % D;
                h_d = pat(ps, sd, h_w);
                model_mem[h_w] = h_d;
                e_we = 1'b1;
            end
            if (m && c <= int'(L) && c < done_c) h_r = (b + c - 1) % D;
            if (!m) m_pass = 1'b1;
            if (m && c == 1) begin m_err = 0; m_fail = 0; end
            if (m && c == done_c) begin
                m_err = e_err; m_fail = e_fail; m_pass = (e_err == 0);
            end
            if (done && seen_done < 0) seen_done = c;
            if (mem_we) we_cnt++;
            check_outputs(m ? "verify" : "fill", c < done_c, c == done_c, e_we,
                          !m || c == 1 || c >= done_c);
            if (c <= done_c) begin
                // Junk on every input: all of it must be ignored while busy or in DONE.
                start = 1'($urandom); mode = 1'($urandom); pat_sel = 1'($urandom);
                seed = W'($urandom); base_addr = $urandom; length = $urandom;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        int seen, wec;
        logic [W-1:0] r8_before;
        reset = 1'b1; start = 1'b0; mode = 1'b0; pat_sel = 1'b0; seed = '0;
        base_addr = '0; length = '0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;

        // Full-range FILL then VERIFY, address-derived pattern.
        do_op(1'b0, 1'b1, 1'b0, 0, D, -1, seen, wec);
        chk("full_fill_done_cycle", 64'(seen), 64'd32769);
        chk("full_fill_we_cycles", 64'(wec), 64'd32768);
        do_op(1'b1, 1'b1, 1'b0, 0, D, -1, seen, wec);
        chk("full_verify_done_cycle", 64'(seen), 64'd32770);
        chk("full_verify_pass", 64'(pass), 64'd1);
        chk("full_verify_err", 64'(err_cnt), 64'd0);

        // Constant-pattern mismatch over 100..109.
        do_op(1'b0, 1'b0, 1'b1, 100, 10, -1, seen, wec);
        do_op(1'b1, 1'b0, 1'b0, 100, 10, -1, seen, wec);
`ifdef MEM_SWEEP_STOP_ON_FAIL_EN
        chk("const_mis_err", 64'(err_cnt), 64'd1);
`else
        chk("const_mis_err", 64'(err_cnt), 64'd10);
`endif
        chk("const_mis_fail_addr", 64'(fail_addr), 64'd100);
        chk("const_mis_pass", 64'(pass), 64'd0);

        // Wrapping FILL across the top of the RAM.
        r8_before = ram[8];
        chk("wrap_addr8_initial", 64'(r8_before), 64'd0);
        do_op(1'b0, 1'b1, 1'b1, 32760, 16, -1, seen, wec);
        chk("wrap_we_cycles", 64'(wec), 64'd16);
        chk("wrap_addr8_unchanged", 64'(ram[8]), 64'(r8_before));
        chk("wrap_ram_32760", 64'(ram[32760]), 64'd1);
        chk("wrap_ram_7", 64'(ram[7]), 64'd0);

        // Zero-length sweeps.
        do_op(1'b1, 1'b1, 1'b0, 5, 0, -1, seen, wec);
        chk("len0_verify_done_cycle", 64'(seen), 64'd1);
        do_op(1'b0, 1'b1, 1'b0, 5, 0, -1, seen, wec);
        chk("len0_fill_done_cycle", 64'(seen), 64'd1);
        chk("len0_fill_we_cycles", 64'(wec), 64'd0);

        // Reset halfway through a 1000-word FILL, then VERIFY the range.
        do_op(1'b0, 1'b0, 1'b1, 0, 1000, 501, seen, wec);
        chk("abort_seen_done", 64'(seen), 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(1'b1, 1'b0, 1'b1, 0, 1000, -1, seen, wec);
`ifdef MEM_SWEEP_STOP_ON_FAIL_EN
        chk("abort_verify_err", 64'(err_cnt), 64'd1);
`else
        chk("abort_verify_err", 64'(err_cnt), 64'd250);
`endif
        chk("abort_verify_fail_addr", 64'(fail_addr), 64'd500);

        // Randomized sweeps with occasional planted corruption.
        for (int i = 0; i < 40; i++) begin
            int unsigned rb;
            if ($urandom_range(0, 2) == 0) corrupt($urandom % D);
            rb = ($urandom_range(0, 1) == 0) ? (D - 1 - $urandom_range(0, 40)) : $urandom;
            do_op(1'($urandom), 1'($urandom), W'($urandom), rb, $urandom_range(0, 60), -1, seen, wec);
        end

`ifdef MEM_SWEEP_STOP_ON_FAIL_EN
        do_op(1'b0, 1'b1, 1'b0, 0, 64, -1, seen, wec);
        corrupt(5);
        do_op(1'b1, 1'b1, 1'b0, 0, 64, -1, seen, wec);
        chk("stop_done_cycle", 64'(seen), 64'd8);
        chk("stop_err", 64'(err_cnt), 64'd1);
        chk("stop_fail_addr", 64'(fail_addr), 64'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
